// File: rtl/l0_skew_feeder_pkg.sv
// l0_skew_feeder shared definitions: instruction fields and cmd codes.
// Shared with mac_tile and the array controller.
package l0_skew_feeder_pkg;

  localparam int INST_W = 3;
  localparam logic [INST_W-1:0] INST_LOAD = 3'b001;
  localparam logic [INST_W-1:0] INST_EXEC = 3'b010;
  localparam int INST_SIMD_BIT = 2;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_LOAD = 2'b01,
    CMD_EXEC = 2'b10,
    CMD_RSVD = 2'b11
  } cmd_e;

  function automatic logic cmd_issues(
    input logic [1:0] c
  );
    return (c == CMD_LOAD) || (c == CMD_EXEC);
  endfunction

  function automatic logic [INST_W-1:0] mk_inst(
    input logic       simd,
    input logic [1:0] c
  );
    logic [INST_W-1:0] i;
    i = '0;
    if (c == CMD_LOAD) i = i | INST_LOAD;
    if (c == CMD_EXEC) i = i | INST_EXEC;
    i[INST_SIMD_BIT] = simd;
    return i;
  endfunction

endpackage

// File: rtl/l0_skew_feeder_skew_delay.sv
// skew_delay: N-deep register chain, synchronous reset.
// N=0 is a plain wire; busy_o flags any non-zero inst field held.
module skew_delay
  import l0_skew_feeder_pkg::*;
#(
  parameter int N  = 1,
  parameter int W  = 7,
  parameter int IW = 3
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         busy_o
);

  if (N == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = clk_i | reset_i;
    assign q_o    = d_i;
    assign busy_o = 1'b0;
  end else begin : g_chain
    logic [W-1:0] st_q [N];

    // shift the lane one stage per cycle
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        for (int i = 0; i < N; i++) st_q[i] <= '0;
      end else begin
        st_q[0] <= d_i;
        for (int i = 1; i < N; i++) st_q[i] <= st_q[i-1];
      end
    end

    // any stage carrying a live instruction keeps the row busy
    always_comb begin
      busy_o = 1'b0;
      for (int i = 0; i < N; i++)
        busy_o = busy_o | (|st_q[i][W-1:W-IW]);
    end

    assign q_o = st_q[N-1];
  end

endmodule

// File: rtl/l0_skew_feeder.sv
// l0_skew_feeder: west-side FIFO feeder with per-row diagonal skew.
// Build macro L0_SKEW_EN enables the skew; otherwise rows are aligned.
module l0_skew_feeder
  import l0_skew_feeder_pkg::*;
#(
  parameter int row   = 8,
  parameter int bw    = 4,
  parameter int depth = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [row*bw-1:0]       in,
  input  logic                    wr,
  input  logic                    rd,
  input  logic [1:0]              cmd,
  input  logic                    simd,
  output logic [row*bw-1:0]       out,
  output logic [row*INST_W-1:0]   inst,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(depth):0]  count,
  output logic                    busy
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam int LW = bw + INST_W;

  logic [row*bw-1:0] mem_q [depth];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push, pop;
  logic [row*bw-1:0] iss_dat_q, iss_dat_d;
  logic [INST_W-1:0] iss_ins_q, iss_ins_d;
  logic [row-1:0]    row_busy;

  assign push = wr & ~full_q;
  assign pop  = rd & ~empty_q & cmd_issues(cmd);

  // pointer, occupancy and issue-stage next state
  always_comb begin
    wptr_d    = wptr_q + AW'(push);
    rptr_d    = rptr_q + AW'(pop);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    full_d    = (cnt_d == CW'(depth));
    empty_d   = (cnt_d == '0);
    iss_dat_d = '0;
    iss_ins_d = '0;
    if (pop) begin
      iss_dat_d = mem_q[rptr_q];
      iss_ins_d = mk_inst(simd, cmd);
    end
  end

  // storage array; stale contents are unreachable after reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in;
  end

  // FIFO state, status flags and the row-0 issue register
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      iss_dat_q <= '0;
      iss_ins_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      iss_dat_q <= iss_dat_d;
      iss_ins_q <= iss_ins_d;
    end
  end

  for (genvar r = 0; r < row; r++) begin : g_row
    logic [LW-1:0] lane;
`ifdef L0_SKEW_EN
    skew_delay #(
      .N  (r),
      .W  (LW),
      .IW (INST_W)
    ) u_dly (
      .clk_i   (clk),
      .reset_i (reset),
      .d_i     ({iss_ins_q, iss_dat_q[r*bw +: bw]}),
      .q_o     (lane),
      .busy_o  (row_busy[r])
    );
`else
    assign lane        = {iss_ins_q, iss_dat_q[r*bw +: bw]};
    assign row_busy[r] = 1'b0;
`endif
    assign out[r*bw +: bw]          = lane[bw-1:0];
    assign inst[r*INST_W +: INST_W] = lane[LW-1:bw];
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign count = cnt_q;
  assign busy  = (|iss_ins_q) | (|row_busy);

endmodule

// File: tb/tb_l0_skew_feeder.sv
// tb_l0_skew_feeder: directed stimulus with a cycle-tagged scoreboard.
// Row 7 latency follows L0_SKEW_EN.
module tb_l0_skew_feeder;

`ifdef L0_SKEW_EN
  localparam int SK = 7;
`else
  localparam int SK = 0;
`endif

  localparam int K_R0   = 0;
  localparam int K_R7   = 1;
  localparam int K_CNT  = 2;
  localparam int K_FULL = 3;
  localparam int K_EMP  = 4;
  localparam int K_BUSY = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in;
  logic        wr, rd, simd;
  logic [1:0]  cmd;
  logic [31:0] out;
  logic [23:0] inst;
  logic        full, empty, busy;
  logic [4:0]  count;

  l0_skew_feeder #(.row(8), .bw(4), .depth(16)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .wr    (wr),
    .rd    (rd),
    .cmd   (cmd),
    .simd  (simd),
    .out   (out),
    .inst  (inst),
    .full  (full),
    .empty (empty),
    .count (count),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int unsigned cyc;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] act(input int k);
    case (k)
      K_R0:    return {25'd0, inst[2:0], out[3:0]};
      K_R7:    return {25'd0, inst[23:21], out[31:28]};
      K_CNT:   return {27'd0, count};
      K_FULL:  return {31'd0, full};
      K_EMP:   return {31'd0, empty};
      default: return {31'd0, busy};
    endcase
  endfunction

  function automatic logic [31:0] rv(input logic [2:0] i,
                                     input logic [3:0] d);
    return {25'd0, i, d};
  endfunction

  task automatic ex(input int k, input int unsigned c,
                    input logic [31:0] v, input string nm);
    exp_t t;
    t.kind = k;
    t.cyc  = c;
    t.val  = v;
    t.name = nm;
    sb.push_back(t);
  endtask

  // monitor: compare every expectation tagged for the current edge
  always @(negedge clk) begin
    exp_t keep[$];
    logic [31:0] a;
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        a = act(sb[i].kind);
        n_chk++;
        if (a !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s edge %0d: got %0h want %0h",
                   sb[i].name, cyc, a, sb[i].val);
        end
      end else if (sb[i].cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s edge %0d: got expired want checked",
                 sb[i].name, sb[i].cyc);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic drv(input logic w, input logic [3:0] v,
                     input logic r, input logic [1:0] c,
                     input logic s);
    wr   = w;
    in   = {8{v}};
    rd   = r;
    cmd  = c;
    simd = s;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  v3 [3] = '{4'd3, 4'd5, 4'd7};
  int unsigned e;

  initial begin
    reset = 1'b1;
    drv(0, 0, 0, 0, 0);
    tick;
    e = cyc + 1;
    ex(K_CNT,  e, 0, "rst_cnt");
    ex(K_FULL, e, 0, "rst_full");
    ex(K_EMP,  e, 1, "rst_empty");
    ex(K_BUSY, e, 0, "rst_busy");
    ex(K_R0,   e, 0, "rst_row0");
    ex(K_R7,   e, 0, "rst_row7");
    tick;
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      drv(1, v3[i], 0, 0, 0);
      e = cyc + 1;
      ex(K_R0, e, 0, "wr_only_inst");
      if (i == 2) begin
        ex(K_CNT, e, 3, "cnt3");
        ex(K_EMP, e, 0, "nonempty");
      end
      tick;
    end

    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 1, 2'b01, 0);
      e = cyc + 1;
      ex(K_R0, e, rv(3'b001, v3[i]), "load_row0");
      ex(K_R7, e + SK, rv(3'b001, v3[i]), "load_row7");
      if (i == 2) begin
        ex(K_CNT,  e, 0, "drained_cnt");
        ex(K_EMP,  e, 1, "drained_empty");
        ex(K_BUSY, e + SK, 1, "busy_tail");
        ex(K_BUSY, e + SK + 1, 0, "busy_drop");
        ex(K_R7,   e + SK + 1, 0, "row7_idle");
      end
      tick;
    end
    drv(0, 0, 0, 0, 0);
    repeat (SK + 2) tick;

    for (int i = 0; i < 16; i++) begin
      drv(1, 4'(i), 0, 0, 0);
      e = cyc + 1;
      if (i == 15) begin
        ex(K_FULL, e, 1, "full");
        ex(K_CNT,  e, 16, "cnt16");
      end
      tick;
    end
    drv(1, 4'd9, 0, 0, 0);
    e = cyc + 1;
    ex(K_CNT,  e, 16, "wr_full_drop");
    ex(K_FULL, e, 1, "still_full");
    tick;
    drv(1, 4'd9, 1, 2'b01, 0);
    e = cyc + 1;
    ex(K_R0,   e, rv(3'b001, 4'd0), "full_wrrd_pop");
    ex(K_CNT,  e, 15, "full_wrrd_cnt");
    ex(K_FULL, e, 0, "full_clear");
    tick;
    for (int i = 1; i < 16; i++) begin
      drv(0, 0, 1, 2'b01, 0);
      e = cyc + 1;
      ex(K_R0, e, rv(3'b001, 4'(i)), "fill_order");
      if (i == 15) begin
        ex(K_CNT, e, 0, "fill_drain_cnt");
        ex(K_EMP, e, 1, "fill_drain_empty");
      end
      tick;
    end

    drv(0, 0, 1, 2'b01, 0);
    e = cyc + 1;
    ex(K_R0,  e, 0, "rd_empty_bubble");
    ex(K_CNT, e, 0, "rd_empty_cnt");
    tick;
    drv(1, 4'hA, 1, 2'b01, 0);
    e = cyc + 1;
    ex(K_R0,  e, 0, "wrrd_empty_bubble");
    ex(K_CNT, e, 1, "wrrd_empty_cnt");
    ex(K_EMP, e, 0, "wrrd_empty_flag");
    tick;
    drv(0, 0, 1, 2'b01, 0);
    e = cyc + 1;
    ex(K_R0, e, rv(3'b001, 4'hA), "no_bypass_word");
    tick;
    drv(1, 4'b0101, 0, 0, 0);
    tick;
    drv(0, 0, 1, 2'b10, 1);
    e = cyc + 1;
    ex(K_R0, e, rv(3'b110, 4'b0101), "exec_simd");
    tick;
    drv(1, 4'd6, 0, 0, 0);
    tick;
    drv(0, 0, 1, 2'b11, 1);
    e = cyc + 1;
    ex(K_R0,  e, 0, "cmd11_bubble");
    ex(K_CNT, e, 1, "cmd11_no_pop");
    tick;

    for (int i = 1; i <= 6; i++) begin
      drv(1, 4'(i), 0, 0, 0);
      tick;
    end
    drv(0, 0, 1, 2'b01, 0);
    e = cyc + 1;
    ex(K_R0, e, rv(3'b001, 4'd6), "pre_rst_a");
    tick;
    drv(0, 0, 1, 2'b01, 0);
    e = cyc + 1;
    ex(K_R0,  e, rv(3'b001, 4'd1), "pre_rst_b");
    ex(K_CNT, e, 5, "pre_rst_cnt");
    tick;
    drv(0, 0, 0, 0, 0);
    reset = 1'b1;
    e = cyc + 1;
    ex(K_R0,   e, 0, "mid_rst_row0");
    ex(K_R7,   e, 0, "mid_rst_row7");
    ex(K_EMP,  e, 1, "mid_rst_empty");
    ex(K_CNT,  e, 0, "mid_rst_cnt");
    ex(K_BUSY, e, 0, "mid_rst_busy");
    ex(K_FULL, e, 0, "mid_rst_full");
    ex(K_R7,   e + 1, 0, "post_rst_row7");
    tick;
    reset = 1'b0;

    drv(1, 4'd0, 0, 0, 0);
    tick;
    for (int j = 1; j <= 40; j++) begin
      drv(1, 4'(j % 16), 1, 2'b01, 0);
      e = cyc + 1;
      ex(K_R0, e, rv(3'b001, 4'((j - 1) % 16)), "wrap_order");
      if (j == 40) ex(K_CNT, e, 1, "wrap_cnt");
      tick;
    end
    drv(0, 0, 1, 2'b01, 0);
    e = cyc + 1;
    ex(K_R0,  e, rv(3'b001, 4'd8), "wrap_last");
    ex(K_EMP, e, 1, "wrap_empty");
    tick;
    drv(0, 0, 0, 0, 0);

    for (int i = 0; i < 40 && sb.size() > 0; i++) tick;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
